// File: rtl/s16x4_bus_arbiter.sv
// Two-master Wishbone arbiter for the S16X4A memory port.
// Master 0 is the CPU, master 1 is DMA or video fetch. Masters take turns
// (round-robin) and the choice is made again after every transfer. A watchdog
// ends a stalled slave cycle with ack + abort, so the CPU discards the result
// instead of waiting forever.
module s16x4_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic        clk_i,
  input  logic        reset,

  input  logic [14:0] m0_adr_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic [1:0]  m0_sel_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_abort_o,

  input  logic [14:0] m1_adr_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic [1:0]  m1_sel_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_abort_o,

  output logic [14:0] s_adr_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [1:0]  s_sel_o,
  output logic [15:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [15:0] s_dat_i,

  output logic [1:0]  gnt_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwn0 = 2'd1;
  localparam logic [1:0] StOwn1 = 2'd2;

  localparam logic [TIMEOUT_W-1:0] WdogLimit = TIMEOUT_W'(TIMEOUT);

  logic [1:0]           state_q, state_d;
  logic                 last_q, last_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic own0, own1;
  logic wdog_expired;
  logic term0, term1;

  assign own0         = (state_q == StOwn0);
  assign own1         = (state_q == StOwn1);
  assign wdog_expired = (wdog_q == WdogLimit);

  // A transfer ends on the slave's ack or when the watchdog runs out.
  assign term0 = own0 & m0_cyc_i & (s_ack_i | wdog_expired);
  assign term1 = own1 & m1_cyc_i & (s_ack_i | wdog_expired);

  assign m0_ack_o   = term0;
  assign m1_ack_o   = term1;
  // A real ack in the same cycle wins over the timeout, so there is no abort.
  assign m0_abort_o = own0 & m0_cyc_i & ~s_ack_i & wdog_expired;
  assign m1_abort_o = own1 & m1_cyc_i & ~s_ack_i & wdog_expired;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {own1, own0};
  assign s_stb_o  = s_cyc_o;

  // Slave-side mux: pass the owner's request through; drive zeros when idle.
  always_comb begin
    s_adr_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_sel_o = '0;
    s_dat_o = '0;
    case (state_q)
      StOwn0: begin
        s_adr_o = m0_adr_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
      end
      StOwn1: begin
        s_adr_o = m1_adr_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // Grant selection: round-robin on ties, hand over only at termination or cyc drop.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (m0_cyc_i) begin
          state_d = StOwn0;
        end else if (m1_cyc_i) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (term0) begin
          last_d = 1'b0;
          // Keep the bus if nobody else wants it: back-to-back fetches run without gaps.
          if (m1_cyc_i) state_d = StOwn1;
        end else if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? StOwn1 : StIdle;
        end
      end
      StOwn1: begin
        if (term1) begin
          last_d = 1'b1;
          if (m0_cyc_i) state_d = StOwn0;
        end else if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? StOwn0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Watchdog: count stalled cycles of the current transfer; restart on anything else.
  always_comb begin
    wdog_d = '0;
    if (s_cyc_o && !s_ack_i && !wdog_expired && (state_d == state_q)) begin
      wdog_d = wdog_q + TIMEOUT_W'(1);
    end
  end

  // State registers with synchronous reset; last starts at 1 so master 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_s16x4_bus_arbiter.sv
// Self-checking bench for s16x4_bus_arbiter: directed scenarios plus a
// randomized run compared against a cycle model of the arbitration rules.
module tb_s16x4_bus_arbiter;

  localparam int unsigned Timeout = 15;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset;
  logic [14:0] adr  [2];
  logic        we   [2];
  logic        cyc  [2];
  logic [1:0]  sel  [2];
  logic [15:0] wdat [2];
  logic        s_ack_i;
  logic [15:0] s_dat_i;

  logic [15:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_abort_o, m1_ack_o, m1_abort_o;
  logic [14:0] s_adr_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [1:0]  s_sel_o;
  logic [15:0] s_dat_o;
  logic [1:0]  gnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: owner is -1 (nobody), 0 or 1; stall counts unacked owner cycles.
  int own   = -1;
  int last  = 1;
  int stall = 0;

  s16x4_bus_arbiter #(
    .TIMEOUT   (Timeout),
    .TIMEOUT_W (4)
  ) dut (
    .clk_i      (clk_i),
    .reset      (reset),
    .m0_adr_i   (adr[0]),
    .m0_we_i    (we[0]),
    .m0_cyc_i   (cyc[0]),
    .m0_sel_i   (sel[0]),
    .m0_dat_i   (wdat[0]),
    .m0_dat_o   (m0_dat_o),
    .m0_ack_o   (m0_ack_o),
    .m0_abort_o (m0_abort_o),
    .m1_adr_i   (adr[1]),
    .m1_we_i    (we[1]),
    .m1_cyc_i   (cyc[1]),
    .m1_sel_i   (sel[1]),
    .m1_dat_i   (wdat[1]),
    .m1_dat_o   (m1_dat_o),
    .m1_ack_o   (m1_ack_o),
    .m1_abort_o (m1_abort_o),
    .s_adr_o    (s_adr_o),
    .s_we_o     (s_we_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_sel_o    (s_sel_o),
    .s_dat_o    (s_dat_o),
    .s_ack_i    (s_ack_i),
    .s_dat_i    (s_dat_i),
    .gnt_o      (gnt_o)
  );

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_tick();
    int  nxt;
    bit  done;
    if (reset) begin
      own = -1; last = 1; stall = 0;
      return;
    end
    done = (own >= 0) && cyc[own] && (s_ack_i || stall == Timeout);
    if (own < 0) begin
      if (cyc[0] && cyc[1]) nxt = 1 - last;
      else if (cyc[0])      nxt = 0;
      else if (cyc[1])      nxt = 1;
      else                  nxt = -1;
    end else if (done) begin
      last = own;
      nxt  = cyc[1 - own] ? 1 - own : own;
    end else if (!cyc[own]) begin
      nxt = cyc[1 - own] ? 1 - own : -1;
    end else begin
      nxt = own;
    end
    if (own >= 0 && cyc[own] && !done && nxt == own) stall = stall + 1;
    else stall = 0;
    own = nxt;
  endtask

  function automatic logic [73:0] model_outputs();
    logic [1:0]  g;
    logic        c, w;
    logic [1:0]  sl;
    logic [14:0] a;
    logic [15:0] d;
    logic [3:0]  term;
    bit          to;
    g = 2'b00; c = 1'b0; w = 1'b0; sl = 2'b00; a = '0; d = '0; term = 4'b0000;
    to = (stall == Timeout);
    if (own >= 0) begin
      g[own] = 1'b1;
      c  = cyc[own]; w = we[own]; sl = sel[own]; a = adr[own]; d = wdat[own];
      if (cyc[own] && (s_ack_i || to)) begin
        // term = {m0_ack, m0_abort, m1_ack, m1_abort}
        if (own == 0) term[3] = 1'b1; else term[1] = 1'b1;
        if (!s_ack_i) begin
          if (own == 0) term[2] = 1'b1; else term[0] = 1'b1;
        end
      end
    end
    return {g, c, c, w, sl, a, d, term, s_dat_i, s_dat_i};
  endfunction

  task automatic tick();
    model_tick();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; we[i] = 1'b0; sel[i] = 2'b11; adr[i] = '0; wdat[i] = '0;
    end
    s_ack_i = 1'b0;
    s_dat_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cyc[0] = 1'b1; cyc[1] = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({gnt_o, s_cyc_o, m0_ack_o, m0_abort_o, m1_ack_o, m1_abort_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b cyc=%b acks=%b%b%b%b, want all 0", gnt_o,
               s_cyc_o, m0_ack_o, m0_abort_o, m1_ack_o, m1_abort_o);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got gnt=%b s_cyc=%b, want 00/0", gnt_o, s_cyc_o);
    end
    tick();
    #1;
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant: got gnt=%b, want 01", gnt_o);
    end
    cyc[0] = 1'b0; cyc[1] = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    idle_inputs();
    cyc[0] = 1'b1; adr[0] = 15'h1234;
    #1;
    checks++;
    if (s_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL read_latency: got s_cyc=%b on request cycle, want 0", s_cyc_o);
    end
    tick();
    #1;
    checks++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 15'h1234 || gnt_o !== 2'b01 || m0_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL read_grant: got cyc=%b adr=%h gnt=%b ack=%b, want 1/1234/01/0", s_cyc_o,
               s_adr_o, gnt_o, m0_ack_o);
    end
    tick();
    #1;
    checks++;
    if (m0_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL read_wait2: got m0_ack=%b, want 0", m0_ack_o);
    end
    tick();
    s_ack_i = 1'b1; s_dat_i = 16'hBEEF;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 16'hBEEF || m1_ack_o !== 1'b0 || m0_abort_o !== 1'b0)
    begin
      errors++;
      $display("FAIL read_ack: got ack0=%b dat=%h ack1=%b abort0=%b, want 1/beef/0/0",
               m0_ack_o, m0_dat_o, m1_ack_o, m0_abort_o);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    int exp_own;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc[0] = 1'b1; cyc[1] = 1'b1;
    adr[0] = 15'h0111; adr[1] = 15'h0222;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_own = (i / 2) % 2;
      s_ack_i = 1'(i % 2);
      #1;
      checks++;
      if (gnt_o !== 2'(1 << exp_own) || s_adr_o !== adr[exp_own] ||
          m0_ack_o !== (exp_own == 0 && s_ack_i) || m1_ack_o !== (exp_own == 1 && s_ack_i)) begin
        errors++;
        $display("FAIL contention_%0d: got gnt=%b adr=%h ack0=%b ack1=%b, want owner m%0d",
                 i, gnt_o, s_adr_o, m0_ack_o, m1_ack_o, exp_own);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    idle_inputs();
    cyc[1] = 1'b1; we[1] = 1'b1; wdat[1] = 16'h00AA; adr[1] = 15'h0040;
    tick();
    for (int i = 0; i < int'(Timeout); i++) begin
      #1;
      checks++;
      if (gnt_o !== 2'b10 || m1_ack_o !== 1'b0 || m1_abort_o !== 1'b0 ||
          s_dat_o !== 16'h00AA || s_we_o !== 1'b1) begin
        errors++;
        $display("FAIL timeout_stall_%0d: got gnt=%b ack=%b abort=%b dat=%h we=%b", i, gnt_o,
                 m1_ack_o, m1_abort_o, s_dat_o, s_we_o);
      end
      tick();
    end
    #1;
    checks++;
    if (m1_ack_o !== 1'b1 || m1_abort_o !== 1'b1 || m0_ack_o !== 1'b0 || m0_abort_o !== 1'b0)
    begin
      errors++;
      $display("FAIL timeout_expire: got ack1=%b abort1=%b ack0=%b abort0=%b, want 1 1 0 0",
               m1_ack_o, m1_abort_o, m0_ack_o, m0_abort_o);
    end
    tick();
    #1;
    checks++;
    if (m1_ack_o !== 1'b0 || m1_abort_o !== 1'b0 || gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL timeout_wdog_clear: got ack1=%b abort1=%b gnt=%b, want 0 0 10", m1_ack_o,
               m1_abort_o, gnt_o);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_ack_at_expiry();
    idle_inputs();
    cyc[0] = 1'b1;
    tick();
    for (int i = 0; i < int'(Timeout); i++) tick();
    s_ack_i = 1'b1;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1 || m0_abort_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_at_expiry: got ack0=%b abort0=%b, want 1 0", m0_ack_o, m0_abort_o);
    end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    idle_inputs();
    cyc[1] = 1'b1;
    tick();
    tick();
    cyc[0] = 1'b1;
    reset  = 1'b1;
    tick();
    #1;
    checks++;
    if ({gnt_o, s_cyc_o, m0_ack_o, m0_abort_o, m1_ack_o, m1_abort_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid: got gnt=%b cyc=%b acks=%b%b%b%b, want all 0", gnt_o, s_cyc_o,
               m0_ack_o, m0_abort_o, m1_ack_o, m1_abort_o);
    end
    reset = 1'b0;
    tick();
    #1;
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_regrant: got gnt=%b, want 01", gnt_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [73:0] got, want;
    int ack_pct;
    idle_inputs();
    for (int i = 0; i < 1200; i++) begin
      if (i % 60 == 0) begin
        case ($urandom_range(3))
          0: ack_pct = 0;
          1: ack_pct = 5;
          2: ack_pct = 40;
          default: ack_pct = 90;
        endcase
      end
      reset = ($urandom_range(199) == 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(99) < 20) cyc[m] = ~cyc[m];
        adr[m]  = 15'($urandom);
        we[m]   = 1'($urandom);
        sel[m]  = 2'($urandom);
        wdat[m] = 16'($urandom);
      end
      s_ack_i = ($urandom_range(99) < ack_pct);
      s_dat_i = 16'($urandom);
      #1;
      got  = {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
              m0_ack_o, m0_abort_o, m1_ack_o, m1_abort_o, m0_dat_o, m1_dat_o};
      want = model_outputs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h want %h", i, got, want);
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk_i);
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid_transfer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
